// File: rtl/axi_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_pkg
//  Description : Shared types and sizing helper for the AXI-stream word packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pack_state_t;

    function automatic int lanes_f(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_word_packer_sva.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_word_packer_sva
//  Description : Handshake properties for axi_stream_word_packer, bound in.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_word_packer_sva #(
    parameter int OUT_WIDTH = 512,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_ready,
    input  logic                 m_valid,
    input  logic                 m_ready,
    input  logic [OUT_WIDTH-1:0] m_data,
    input  logic                 m_last,
    input  logic [CNT_W-1:0]     m_words
);

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (m_valid && !m_ready) |=> $stable({m_data, m_last, m_words}));

    a_ready_excl: assert property (@(posedge clk) disable iff (reset)
        s_ready |-> !m_valid);

    a_words_nonzero: assert property (@(posedge clk) disable iff (reset)
        m_valid |-> (m_words != '0));

endmodule

bind axi_stream_word_packer axi_stream_word_packer_sva #(
    .OUT_WIDTH (OUT_WIDTH),
    .CNT_W     (CNT_W)
) u_sva (
    .clk     (clk),
    .reset   (reset),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_words (m_words)
);
`default_nettype wire

// File: rtl/axi_stream_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_word_packer
//  Description : Packs narrow AXI-stream words big-endian into OUT_WIDTH blocks,
//                zero-filling the unused lanes of a block closed by s_last.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_word_packer
    import axi_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 512,
    localparam int LANES    = lanes_f(OUT_WIDTH, IN_WIDTH),
    localparam int CNT_W    = $clog2(LANES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [CNT_W-1:0]     m_words
);

    generate
        if (OUT_WIDTH % IN_WIDTH != 0) begin : g_width_check
            $error("OUT_WIDTH must be a multiple of IN_WIDTH");
        end
    endgenerate

    pack_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_idx, w_idx_nxt;
    logic [OUT_WIDTH-1:0]   r_buf, w_buf_nxt;
    logic                   r_last, w_last_nxt;
    logic [CNT_W-1:0]       r_words, w_words_nxt;
    logic                   w_accept;
    logic                   w_close;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_buf_nxt   = r_buf;
        w_last_nxt  = r_last;
        w_words_nxt = r_words;
        w_accept    = s_valid && (r_state == FILL);
        w_close     = w_accept && ((r_idx == CNT_W'(LANES - 1)) || s_last);

        case (r_state)
            FILL: begin
                if (w_accept) begin
                    // Lane write and zero-fill of higher lanes land in the same update.
                    for (int l = 0; l < LANES; l++) begin
                        if (CNT_W'(l) == r_idx) begin
                            w_buf_nxt[OUT_WIDTH-1-l*IN_WIDTH -: IN_WIDTH] = s_data;
                        end else if (w_close && (CNT_W'(l) > r_idx)) begin
                            w_buf_nxt[OUT_WIDTH-1-l*IN_WIDTH -: IN_WIDTH] = '0;
                        end
                    end
                    if (w_close) begin
                        w_state_nxt = EMIT;
                        w_idx_nxt   = '0;
                        w_words_nxt = r_idx + CNT_W'(1);
                        w_last_nxt  = s_last;
                    end else begin
                        w_idx_nxt   = r_idx + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (m_ready) begin
                    w_state_nxt = FILL;
                    w_buf_nxt   = '0;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_buf   <= '0;
            r_last  <= 1'b0;
            r_words <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_buf   <= w_buf_nxt;
            r_last  <= w_last_nxt;
            r_words <= w_words_nxt;
        end
    end

    assign s_ready = (r_state == FILL);
    assign m_valid = (r_state == EMIT);
    assign m_data  = r_buf;
    assign m_last  = r_last;
    assign m_words = r_words;

endmodule
`default_nettype wire
